// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch stage.
//   fetch_state_e  - fetch FSM states (idle / waiting on ROM / word buffered)
//   DefaultAddrW   - default PC / ROM address width
//   DefaultDataW   - default instruction word width
//   DefaultResetPc - default PC value after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2
  } fetch_state_e;

  localparam int unsigned DefaultAddrW   = 16;
  localparam int unsigned DefaultDataW   = 16;
  localparam int unsigned DefaultResetPc = 0;

endpackage

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage sequenced by clock-controller phase strobes.
//   Clk, rst                 - clock, asynchronous active-high reset
//   instRead/Fetch/Execute   - phase strobes from the clock controller
//   branchTaken/Target       - PC redirect, sampled with instExecute
//   romAddr/romReq           - registered request to instruction ROM (held until accepted)
//   romData/romValid         - ROM response
//   stall                    - holds the controller counter while fetch waits on the ROM
//   instWord/instValid/pcOut - latched instruction and its PC for decode
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = DefaultAddrW,
  parameter int unsigned          DATA_W   = DefaultDataW,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(DefaultResetPc)
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              instRead,
  input  logic              instFetch,
  input  logic              instExecute,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  output logic [ADDR_W-1:0] romAddr,
  output logic              romReq,
  input  logic [DATA_W-1:0] romData,
  input  logic              romValid,
  output logic              stall,
  output logic [DATA_W-1:0] instWord,
  output logic              instValid,
  output logic [ADDR_W-1:0] pcOut
);

  fetch_state_e      state_q, state_d;
  logic              read_q, read_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rom_req_q, rom_req_d;
  logic [DATA_W-1:0] data_buf_q, data_buf_d;
  logic [DATA_W-1:0] inst_word_q, inst_word_d;
  logic              inst_valid_q, inst_valid_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;

  // State register
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      read_q       <= 1'b0;
      pc_q         <= RESET_PC;
      rom_addr_q   <= RESET_PC;
      rom_req_q    <= 1'b0;
      data_buf_q   <= '0;
      inst_word_q  <= '0;
      inst_valid_q <= 1'b0;
      pc_out_q     <= RESET_PC;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      pc_q         <= pc_d;
      rom_addr_q   <= rom_addr_d;
      rom_req_q    <= rom_req_d;
      data_buf_q   <= data_buf_d;
      inst_word_q  <= inst_word_d;
      inst_valid_q <= inst_valid_d;
      pc_out_q     <= pc_out_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    read_d       = instRead;
    pc_d         = pc_q;
    rom_addr_d   = rom_addr_q;
    rom_req_d    = rom_req_q;
    data_buf_d   = data_buf_q;
    inst_word_d  = inst_word_q;
    inst_valid_d = inst_valid_q;
    pc_out_d     = pc_out_q;

    unique case (state_q)
      StIdle: begin
        // read_q resets to 0, so a read phase already high out of reset still starts a fetch
        if (instRead && !read_q) begin
          rom_addr_d = pc_q;
          rom_req_d  = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (rom_req_q && romValid) begin
          rom_req_d  = 1'b0;
          data_buf_d = romData;
          if (instFetch) begin
            // Data and fetch coincide: bypass the buffer
            inst_word_d  = romData;
            pc_out_d     = pc_q;
            inst_valid_d = 1'b1;
            state_d      = StIdle;
          end else begin
            state_d = StReady;
          end
        end
      end
      StReady: begin
        if (instFetch) begin
          inst_word_d  = data_buf_q;
          pc_out_d     = pc_q;
          inst_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Execute updates the PC in any state; a request in flight is left to complete
    if (instExecute) begin
      if (branchTaken) begin
        pc_d         = branchTarget;
        inst_valid_d = 1'b0;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    stall     = instFetch && !((state_q == StReady) || ((state_q == StWait) && romValid));
    romAddr   = rom_addr_q;
    romReq    = rom_req_q;
    instWord  = inst_word_q;
    instValid = inst_valid_q;
    pcOut     = pc_out_q;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        Clk = 1'b0;
  logic        rst;
  logic        instRead, instFetch, instExecute, branchTaken;
  logic [15:0] branchTarget;
  logic [15:0] romAddr;
  logic        romReq;
  logic [15:0] romData;
  logic        romValid;
  logic        stall;
  logic [15:0] instWord;
  logic        instValid;
  logic [15:0] pcOut;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  inst_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
    .Clk          (Clk),
    .rst          (rst),
    .instRead     (instRead),
    .instFetch    (instFetch),
    .instExecute  (instExecute),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .romAddr      (romAddr),
    .romReq       (romReq),
    .romData      (romData),
    .romValid     (romValid),
    .stall        (stall),
    .instWord     (instWord),
    .instValid    (instValid),
    .pcOut        (pcOut)
  );

  // ROM model with programmable latency (0 = valid in the first romReq cycle)
  int       rom_lat = 0;
  int       rom_cnt = 0;
  always @(posedge Clk) begin
    if (!romReq || romValid) rom_cnt <= 0;
    else rom_cnt <= rom_cnt + 1;
  end
  assign romValid = romReq && (rom_cnt >= rom_lat);

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0001: return 16'hC0DE;
      16'h0002: return 16'h0BAD;
      16'h0040: return 16'hBEEF;
      16'hFFFF: return 16'hF00D;
      default:  return 16'hDEAD;
    endcase
  endfunction
  assign romData = rom_word(romAddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboards
  logic [15:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];   // {instWord, pcOut}

  // Address monitor: new request address, and address stable while romReq is held
  logic        req_prev = 1'b0;
  logic [15:0] addr_hold = '0;
  always @(negedge Clk) begin
    if (romReq && !req_prev) begin
      if (exp_addr_q.size() == 0) check("unexpected_req", 32'(romAddr), 32'hFFFF_FFFF);
      else check("romAddr", 32'(romAddr), 32'(exp_addr_q.pop_front()));
      addr_hold = romAddr;
    end else if (romReq) begin
      check("romAddr_stable", 32'(romAddr), 32'(addr_hold));
    end
    req_prev = romReq;
  end

  // Instruction monitor: fetch accepted (instFetch && !stall) -> outputs next cycle
  logic acc_pending = 1'b0;
  always @(negedge Clk) begin
    if (acc_pending) begin
      check("instValid", 32'(instValid), 32'd1);
      if (exp_inst_q.size() == 0) check("unexpected_inst", {instWord, pcOut}, 32'hFFFF_FFFF);
      else check("instWord_pcOut", {instWord, pcOut}, exp_inst_q.pop_front());
    end
    acc_pending = instFetch && !stall && !rst;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One read/fetch/execute sequence of the clock controller
  task automatic fetch_seq(input int lat, input logic br, input logic [15:0] tgt,
                           input logic [15:0] e_addr, input logic [15:0] e_word,
                           input logic [15:0] e_pc, input int e_stalls);
    int stalls = 0;
    bit done = 0;
    rom_lat = lat;
    exp_addr_q.push_back(e_addr);
    exp_inst_q.push_back({e_word, e_pc});
    instRead = 1'b1;
    tick();
    tick();
    instRead  = 1'b0;
    instFetch = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge Clk);
      if (stall) stalls++;
      else done = 1;
      tick();
    end
    if (!done) check("fetch_timeout", 32'd0, 32'd1);
    check("stall_cycles", 32'(stalls), 32'(e_stalls));
    instFetch    = 1'b0;
    instExecute  = 1'b1;
    branchTaken  = br;
    branchTarget = tgt;
    tick();
    instExecute = 1'b0;
    branchTaken = 1'b0;
    if (br) begin
      @(negedge Clk);
      check("flush_instValid", 32'(instValid), 32'd0);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    instRead = 0; instFetch = 0; instExecute = 0; branchTaken = 0; branchTarget = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_romReq", 32'(romReq), 32'd0);
    check("rst_romAddr", 32'(romAddr), 32'h0000);
    check("rst_outputs", {instWord, pcOut}, 32'h0);
    check("rst_instValid", 32'(instValid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    instFetch = 1'b1;
    #1 check("rst_stall_fetch", 32'(stall), 32'd1);
    instFetch = 1'b0;
    @(posedge Clk); #1 rst = 1'b0;

    fetch_seq(0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 0);
    fetch_seq(5, 1'b0, 16'h0000, 16'h0001, 16'hC0DE, 16'h0001, 4);
    fetch_seq(1, 1'b1, 16'h0040, 16'h0002, 16'h0BAD, 16'h0002, 0);
    fetch_seq(0, 1'b1, 16'hFFFF, 16'h0040, 16'hBEEF, 16'h0040, 0);
    fetch_seq(0, 1'b0, 16'h0000, 16'hFFFF, 16'hF00D, 16'hFFFF, 0);
    fetch_seq(0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 0);

    // Reset in the middle of a slow request
    rom_lat = 8;
    exp_addr_q.push_back(16'h0001);
    instRead = 1'b1;
    tick();
    tick();
    check("wait_romReq", 32'(romReq), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_romReq", 32'(romReq), 32'd0);
    check("async_rst_romAddr", 32'(romAddr), 32'h0000);
    check("async_rst_outputs", {instWord, pcOut}, 32'h0);
    check("async_rst_instValid", 32'(instValid), 32'd0);
    tick();
    rst = 1'b0;   // instRead still high: first cycle out of reset is a rising edge
    fetch_seq(0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 0);

    repeat (3) tick();
    check("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    check("inst_queue_empty", 32'(exp_inst_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
